// File: rtl/r2r_adc_engine_if.sv
// Handshake/data bundle between the R2R ADC engine and its user: start/mode/comparator
// into the engine, DAC code, raw/averaged/scaled results and status out of it.
interface r2r_adc_engine_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic             r2r_compare;
  logic [WIDTH-1:0] r2r_bus;
  logic             busy;
  logic             sample_valid;
  logic [WIDTH-1:0] raw_out;
  logic             avg_valid;
  logic [WIDTH-1:0] avg_out;
  logic [15:0]      scaled_out;
  logic             sat_hi;
  logic             sat_lo;

  modport master (
    output start, mode, r2r_compare,
    input  r2r_bus, busy, sample_valid, raw_out, avg_valid, avg_out, scaled_out, sat_hi, sat_lo
  );

  modport slave (
    input  start, mode, r2r_compare,
    output r2r_bus, busy, sample_valid, raw_out, avg_valid, avg_out, scaled_out, sat_hi, sat_lo
  );
endinterface

// File: rtl/r2r_adc_engine.sv
// R2R-DAC + comparator ADC engine: ramp or SAR search, block averager and mV scaler.
// Define R2R_ADC_SAR_EN to compile the SAR search; otherwise every conversion is a ramp.
module r2r_adc_engine #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1000,
  parameter int AVG_POWER     = 6,
  parameter int SCALE_MULT    = 13246,
  parameter int SCALE_SHIFT   = 10
) (
  input  logic            clk,
  input  logic            reset,
  r2r_adc_engine_if.slave adc
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int SCNT_W = $clog2(SETTLE_CYCLES);
  localparam int ACC_W  = WIDTH + AVG_POWER;
  localparam int CNT_W  = (AVG_POWER > 0) ? AVG_POWER : 1;

  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'((1 << AVG_POWER) - 1);
  localparam logic [WIDTH-1:0]  ALL_ONES    = '1;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  code_q, code_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [SCNT_W-1:0] settle_q, settle_d;
  logic [1:0]        sync_q;
  logic [WIDTH-1:0]  raw_q, raw_d;
  logic              sample_valid_q, sample_valid_d;
  logic              sat_hi_q, sat_hi_d;
  logic              sat_lo_q, sat_lo_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;
  logic [15:0]       scaled_q, scaled_d;
  logic [ACC_W-1:0]  acc_sum;
  logic              cmp_s;

`ifdef R2R_ADC_SAR_EN
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  logic             mode_q, mode_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] sar_keep;

  // The trial code already holds result|bit, so keeping the bit means adopting the trial.
  assign sar_keep = cmp_s ? code_q : result_q;
`else
  logic unused_mode;
  assign unused_mode = adc.mode;
`endif

  assign cmp_s   = sync_q[1];
  assign acc_sum = acc_q + ACC_W'(result_q);

  always_comb begin
    // NOTE: every next-state value starts from its hold value so no branch can infer a latch.
    state_d        = state_q;
    code_d         = code_q;
    result_d       = result_q;
    settle_d       = settle_q;
    raw_d          = raw_q;
    sat_hi_d       = sat_hi_q;
    sat_lo_d       = sat_lo_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    avg_d          = avg_q;
    sample_valid_d = 1'b0;
    avg_valid_d    = 1'b0;
    scaled_d       = avg_valid_q ? 16'((32'(avg_q) * 32'(SCALE_MULT)) >> SCALE_SHIFT) : scaled_q;
`ifdef R2R_ADC_SAR_EN
    mode_d         = mode_q;
    bit_d          = bit_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (adc.start) begin
          state_d  = ST_SETTLE;
          result_d = '0;
          settle_d = '0;
`ifdef R2R_ADC_SAR_EN
          mode_d   = adc.mode;
          bit_d    = BIT_W'(WIDTH - 1);
          code_d   = adc.mode ? MSB : '0;
`else
          code_d   = '0;
`endif
        end
      end

      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_DECIDE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SCNT_W'(1);
        end
      end

      ST_DECIDE: begin
`ifdef R2R_ADC_SAR_EN
        if (mode_q) begin
          result_d = sar_keep;
          if (bit_q == '0) begin
            state_d = ST_DONE;
            code_d  = '0;
          end else begin
            state_d = ST_SETTLE;
            bit_d   = bit_q - BIT_W'(1);
            code_d  = sar_keep | (WIDTH'(1) << (bit_q - BIT_W'(1)));
          end
        end else
`endif
        begin
          // Ramp stops at the first code above the input, or saturates at the top code.
          if (!cmp_s) begin
            result_d = (code_q == '0) ? '0 : code_q - WIDTH'(1);
            state_d  = ST_DONE;
            code_d   = '0;
          end else if (code_q == ALL_ONES) begin
            result_d = ALL_ONES;
            state_d  = ST_DONE;
            code_d   = '0;
          end else begin
            code_d   = code_q + WIDTH'(1);
            state_d  = ST_SETTLE;
          end
        end
      end

      ST_DONE: begin
        state_d        = ST_IDLE;
        raw_d          = result_q;
        sample_valid_d = 1'b1;
        sat_hi_d       = (result_q == ALL_ONES);
        sat_lo_d       = (result_q == '0);
        if (cnt_q == CNT_LAST) begin
          avg_d       = WIDTH'(acc_sum >> AVG_POWER);
          avg_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      code_q         <= '0;
      result_q       <= '0;
      settle_q       <= '0;
      sync_q         <= '0;
      raw_q          <= '0;
      sample_valid_q <= 1'b0;
      sat_hi_q       <= 1'b0;
      sat_lo_q       <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      avg_q          <= '0;
      avg_valid_q    <= 1'b0;
      scaled_q       <= '0;
`ifdef R2R_ADC_SAR_EN
      mode_q         <= 1'b0;
      bit_q          <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values, including the sync chain.
      state_q        <= state_d;
      code_q         <= code_d;
      result_q       <= result_d;
      settle_q       <= settle_d;
      sync_q         <= {sync_q[0], adc.r2r_compare};
      raw_q          <= raw_d;
      sample_valid_q <= sample_valid_d;
      sat_hi_q       <= sat_hi_d;
      sat_lo_q       <= sat_lo_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      avg_q          <= avg_d;
      avg_valid_q    <= avg_valid_d;
      scaled_q       <= scaled_d;
`ifdef R2R_ADC_SAR_EN
      mode_q         <= mode_d;
      bit_q          <= bit_d;
`endif
    end
  end

  assign adc.r2r_bus      = code_q;
  assign adc.busy         = (state_q != ST_IDLE);
  assign adc.sample_valid = sample_valid_q;
  assign adc.raw_out      = raw_q;
  assign adc.avg_valid    = avg_valid_q;
  assign adc.avg_out      = avg_q;
  assign adc.scaled_out   = scaled_q;
  assign adc.sat_hi       = sat_hi_q;
  assign adc.sat_lo       = sat_lo_q;

endmodule
